// File: rtl/reaction_game_controller.sv
// Reaction-time game sequencer: random pre-delay, 1 ms tick for the external
// up-counter, reaction capture, false-start and timeout detection.
module reaction_game_controller #(
    parameter int unsigned CLK_PER_MS   = 50000,
    parameter int unsigned MIN_DELAY_MS = 1000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Button,
    input  logic [10:0] Count,
    output logic        CountEnable,
    output logic        CountClearN,
    output logic        Stimulus,
    output logic [10:0] Result,
    output logic        ResultValid,
    output logic        FalseStart,
    output logic        Timeout
);
    localparam int unsigned PRESC_W = $clog2(CLK_PER_MS);
    localparam int unsigned COUNT_W = 11;
    localparam int unsigned DELAY_W = 12;
    localparam int unsigned LFSR_W  = 8;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_MS - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_RAND,
        ARMED,
        DONE,
        FAULT
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 start_d;
    logic                 button_d;
    logic [LFSR_W-1:0]    lfsr;
    logic [LFSR_W-1:0]    seed;
    logic [PRESC_W-1:0]   presc;
    logic [DELAY_W-1:0]   delay_cnt;

    logic                 start_edge;
    logic                 btn_edge;
    logic                 timing;
    logic                 tick;
    logic                 count_enable_n;
    logic                 stimulus_n;
    logic                 clear_n_n;
    logic [COUNT_W-1:0]   result_n;
    logic                 result_valid_n;
    logic                 false_start_n;
    logic                 timeout_n;

    assign start_edge = Start & ~start_d;
    assign btn_edge   = Button & ~button_d;
    assign timing     = (state == WAIT_RAND) || (state == ARMED);
    assign tick       = timing && (presc == PRESC_LAST);

    // Next state and next values of the registered outputs
    always_comb begin
        next_state     = state;
        count_enable_n = 1'b0;
        result_n       = Result;
        result_valid_n = ResultValid;
        false_start_n  = FalseStart;
        timeout_n      = Timeout;
        case (state)
            IDLE: begin
                if (start_edge) next_state = CLEAR;
            end
            CLEAR: begin
                next_state = WAIT_RAND;
            end
            WAIT_RAND: begin
                if (btn_edge) begin
                    next_state    = FAULT;
                    false_start_n = 1'b1;
                end else if (tick && (delay_cnt == DELAY_W'(1))) begin
                    next_state = ARMED;
                end
            end
            ARMED: begin
                if (btn_edge) begin
                    next_state     = DONE;
                    result_n       = Count;
                    result_valid_n = 1'b1;
                end else if (tick) begin
                    if (Count == COUNT_MAX) begin
                        next_state = FAULT;
                        timeout_n  = 1'b1;
                    end else begin
                        count_enable_n = 1'b1;
                    end
                end
            end
            DONE, FAULT: begin
                if (start_edge) next_state = CLEAR;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (next_state == CLEAR) begin
            result_n       = '0;
            result_valid_n = 1'b0;
            false_start_n  = 1'b0;
            timeout_n      = 1'b0;
        end
        stimulus_n = (next_state == ARMED);
        clear_n_n  = !((next_state == IDLE) || (next_state == CLEAR));
    end

    // State and output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            CountEnable <= 1'b0;
            CountClearN <= 1'b0;
            Stimulus    <= 1'b0;
            Result      <= '0;
            ResultValid <= 1'b0;
            FalseStart  <= 1'b0;
            Timeout     <= 1'b0;
        end else begin
            state       <= next_state;
            CountEnable <= count_enable_n;
            CountClearN <= clear_n_n;
            Stimulus    <= stimulus_n;
            Result      <= result_n;
            ResultValid <= result_valid_n;
            FalseStart  <= false_start_n;
            Timeout     <= timeout_n;
        end
    end

    // Edge detectors, LFSR (x^8+x^6+x^5+x^4+1), prescaler and delay counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            start_d   <= 1'b0;
            button_d  <= 1'b0;
            lfsr      <= LFSR_W'(8'h01);
            seed      <= '0;
            presc     <= '0;
            delay_cnt <= '0;
        end else begin
            start_d  <= Start;
            button_d <= Button;
            lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (start_edge) seed <= lfsr;
            if (!timing || tick) presc <= '0;
            else                 presc <= presc + PRESC_W'(1);
            if (state == CLEAR) begin
                delay_cnt <= DELAY_W'(MIN_DELAY_MS) + DELAY_W'(seed);
            end else if ((state == WAIT_RAND) && tick) begin
                delay_cnt <= delay_cnt - DELAY_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_reaction_game_controller.sv
// Scoreboard bench for reaction_game_controller with a behavioural 11-bit
// millisecond counter closing the loop on CountEnable/CountClearN.
module tb_reaction_game_controller;
    localparam int K   = 4;
    localparam int MIN = 2;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic        Button;
    logic [10:0] Count;
    logic        CountEnable;
    logic        CountClearN;
    logic        Stimulus;
    logic [10:0] Result;
    logic        ResultValid;
    logic        FalseStart;
    logic        Timeout;

    reaction_game_controller #(
        .CLK_PER_MS  (K),
        .MIN_DELAY_MS(MIN)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Button     (Button),
        .Count      (Count),
        .CountEnable(CountEnable),
        .CountClearN(CountClearN),
        .Stimulus   (Stimulus),
        .Result     (Result),
        .ResultValid(ResultValid),
        .FalseStart (FalseStart),
        .Timeout    (Timeout)
    );

    typedef struct {
        logic        rv;
        logic        fs;
        logic        to;
        logic [10:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          ce_total = 0;
    logic        stim_seen = 1'b0;
    logic        any_q = 1'b0;
    logic        any_now;
    logic [10:0] count_m;
    logic [7:0]  lfsr_m;
    exp_t        e_mon;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc++;

    // Behavioural up-counter feeding Count back to the controller
    always @(posedge Clock) begin
        if (!CountClearN)     count_m <= 11'd0;
        else if (CountEnable) count_m <= count_m + 11'd1;
    end
    assign Count = count_m;

    // Reference LFSR used to predict the random wait
    always @(posedge Clock) begin
        if (Reset) lfsr_m <= 8'h01;
        else       lfsr_m <= {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compare the capture flags against the scoreboard when a round ends
    always @(negedge Clock) begin
        any_now = ResultValid | FalseStart | Timeout;
        if (any_now && !any_q) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 32'(any_now), 32'(0));
            end else begin
                e_mon = sb.pop_front();
                check("result",       32'(Result),      32'(e_mon.res));
                check("result_valid", 32'(ResultValid), 32'(e_mon.rv));
                check("false_start",  32'(FalseStart),  32'(e_mon.fs));
                check("timeout",      32'(Timeout),     32'(e_mon.to));
                check("stim_off",     32'(Stimulus),    32'(0));
                if (e_mon.cyc != 0) check("capture_latency", 32'(cyc), 32'(e_mon.cyc));
            end
        end
        any_q = any_now;
        if (CountEnable) ce_total++;
        if (Stimulus) stim_seen = 1'b1;
    end

    function automatic logic [31:0] outs();
        return 32'({CountEnable, CountClearN, Stimulus, Result, ResultValid, FalseStart, Timeout});
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic rv, input logic fs, input logic to,
                        input logic [10:0] res, input int c);
        exp_t e;
        e.rv = rv; e.fs = fs; e.to = to; e.res = res; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic start_round(output int s_cyc, output int d);
        Start = 1'b1;
        s_cyc = cyc;
        d = MIN + int'(lfsr_m);
        stim_seen = 1'b0;
        step(1);
        Start = 1'b0;
    endtask

    task automatic wait_stim(input int limit, output int rise);
        int n = 0;
        while (!Stimulus && n < limit) begin
            step(1);
            n++;
        end
        rise = cyc;
        check("stim_rise_seen", 32'(Stimulus), 32'(1));
    endtask

    initial begin
        int s, d, rise, ce0, n;
        Reset = 1'b1; Start = 1'b0; Button = 1'b0;

        // Reset then idle
        step(3);
        check("reset_outputs", outs(), 32'(0));
        Reset = 1'b0;
        ce0 = ce_total;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("idle_outputs", outs(), 32'(0));
        end
        check("idle_no_ce", 32'(ce_total - ce0), 32'(0));

        // Normal round, Start on the first cycle after reset
        Reset = 1'b1;
        step(3);
        Reset = 1'b0;
        start_round(s, d);
        check("clear_cn_low", 32'(CountClearN), 32'(0));
        step(1);
        check("wait_cn_high", 32'(CountClearN), 32'(1));
        wait_stim(300, rise);
        check("stim_delay", 32'(rise - s), 32'(2 + d * K));
        step(21);
        check("count_at_press", 32'(count_m), 32'(5));
        Button = 1'b1;
        push(1'b1, 1'b0, 1'b0, 11'd5, cyc + 1);
        step(1);
        Button = 1'b0;
        step(3);

        // False start two ticks into the random wait
        ce0 = ce_total;
        start_round(s, d);
        step(9);
        Button = 1'b1;
        push(1'b0, 1'b1, 1'b0, 11'd0, cyc + 1);
        step(1);
        Button = 1'b0;
        step((d + 2) * K);
        check("fs_no_stim", 32'(stim_seen), 32'(0));
        check("fs_no_ce", 32'(ce_total - ce0), 32'(0));
        check("fs_held", 32'(FalseStart), 32'(1));

        // Timeout: armed and never pressed
        start_round(s, d);
        wait_stim(1200, rise);
        ce0 = ce_total;
        push(1'b0, 1'b0, 1'b1, 11'd0, 0);
        n = 0;
        while (!Timeout && n < 2048 * K + 16) begin
            step(1);
            n++;
        end
        check("to_seen", 32'(Timeout), 32'(1));
        check("to_window", 32'(((cyc - rise) == 2048 * K) || ((cyc - rise) == 2048 * K + 1)), 32'(1));
        check("to_count", 32'(count_m), 32'(2047));
        check("to_ce_pulses", 32'(ce_total - ce0), 32'(2047));
        step(3);

        // Press on the overflow tick: capture wins
        start_round(s, d);
        wait_stim(1200, rise);
        step(2048 * K - 1);
        check("sim_count", 32'(count_m), 32'(2047));
        Button = 1'b1;
        push(1'b1, 1'b0, 1'b0, 11'd2047, cyc + 1);
        step(1);
        Button = 1'b0;
        step(3);
        check("sim_no_timeout", 32'(Timeout), 32'(0));

        // Button held through arming, Start ignored while armed, then re-press
        Button = 1'b1;
        step(2);
        start_round(s, d);
        wait_stim(1200, rise);
        step(10);
        check("held_no_capture", 32'(ResultValid), 32'(0));
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        step(3);
        check("start_ignored_stim", 32'(Stimulus), 32'(1));
        check("start_ignored_cn", 32'(CountClearN), 32'(1));
        Button = 1'b0;
        step(1);
        Button = 1'b1;
        push(1'b1, 1'b0, 1'b0, count_m, cyc + 1);
        step(1);
        Button = 1'b0;
        step(3);

        // Reset in the middle of ARMED
        start_round(s, d);
        wait_stim(1200, rise);
        step(6);
        Reset = 1'b1;
        step(1);
        check("reset_mid_armed", outs(), 32'(0));
        Reset = 1'b0;
        step(5);
        check("after_reset_idle", outs(), 32'(0));

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
